// File: rtl/lcd_capture_if.sv
`default_nettype none
// ============================================================================
// lcd_capture_if
// PicoRV-style memory bus between a master and the lcd_capture register file.
// Revision: 1.0
// ============================================================================
interface lcd_capture_if;
  logic        select;
  logic [3:0]  wstrb;
  logic [11:0] addr;
  logic [31:0] data_i;
  logic        ready;
  logic [31:0] data_o;

  modport master (
    output select, wstrb, addr, data_i,
    input  ready, data_o
  );

  modport slave (
    input  select, wstrb, addr, data_i,
    output ready, data_o
  );
endinterface
`default_nettype wire

// File: rtl/lcd_capture.sv
`default_nettype none
// ============================================================================
// lcd_capture
// Measures a DE-mode RGB stream per frame (width, lines, lit pixels, signature)
// and exposes the results as bus registers.
// Revision: 1.0
// ============================================================================
module lcd_capture #(
  parameter int EXP_WIDTH  = 480,
  parameter int EXP_HEIGHT = 272,
  parameter int VBLANK_MIN = 600
) (
  input  wire        clk,
  input  wire        rst_n,
  lcd_capture_if.slave bus,
  input  wire        dclk,
  input  wire        de,
  input  wire  [7:0] red,
  input  wire  [7:0] green,
  input  wire  [7:0] blue
);

  localparam logic [9:0]  c_exp_width  = 10'(EXP_WIDTH);
  localparam logic [8:0]  c_exp_height = 9'(EXP_HEIGHT);
  localparam logic [15:0] c_vblank_min = 16'(VBLANK_MIN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t      r_state, w_state_next;

  logic        r_dclk_q, r_de_q;
  logic [15:0] r_run_cnt;
  logic [9:0]  r_x_cnt, r_last_width;
  logic [8:0]  r_y_cnt, r_frame_lines;
  logic [19:0] r_lit_acc, r_lit_count;
  logic [31:0] r_sig, r_signature, r_frame_count;
  logic        r_ctrl_en;
  logic [3:0]  r_sticky;                 // {FRAME_DONE, COLOR_ERR, HEIGHT_ERR, WIDTH_ERR}
  logic        r_ready;
  logic [31:0] r_data_o;

  logic        w_smp, w_lit, w_dark, w_active, w_frame, w_line_end, w_latch, w_access;
  logic [15:0] w_run_next;
  logic [3:0]  w_sticky_set, w_w1c;
  logic [9:0]  w_reg;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_smp      = dclk & ~r_dclk_q;
  assign w_lit      = &{red, green, blue};
  assign w_dark     = ~|{red, green, blue};
  assign w_active   = (r_state == ST_ACTIVE);
  assign w_run_next = (r_run_cnt == 16'hFFFF) ? r_run_cnt : r_run_cnt + 16'd1;
  assign w_frame    = w_smp & ~de & (r_state != ST_IDLE) & (w_run_next == c_vblank_min);
  assign w_line_end = w_smp & ~de & r_de_q;
  assign w_latch    = w_active & w_frame & (r_y_cnt != 9'd0);

  assign w_sticky_set[0] = w_active & w_line_end & (r_x_cnt != c_exp_width);
  assign w_sticky_set[1] = w_latch & (r_y_cnt != c_exp_height);
  assign w_sticky_set[2] = w_active & w_smp & de & ~w_lit & ~w_dark;
  assign w_sticky_set[3] = w_latch;

  assign w_access = bus.select & ~r_ready;
  assign w_reg    = bus.addr[11:2];
  assign w_w1c    = (w_access && bus.wstrb[0] && w_reg == 10'd1) ? bus.data_i[4:1] : 4'd0;
  assign w_unused = &{1'b0, bus.addr[1:0], bus.wstrb[3:1], bus.data_i[31:5]};

  assign bus.ready  = r_ready;
  assign bus.data_o = r_data_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (r_ctrl_en) w_state_next = ST_SYNC;
      ST_SYNC:   if (!r_ctrl_en) w_state_next = ST_IDLE;
                 else if (w_frame) w_state_next = ST_ACTIVE;
      ST_ACTIVE: if (!r_ctrl_en) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Pixel path: everything but the dclk edge detector advances only on a sample strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dclk_q      <= 1'b0;
      r_de_q        <= 1'b0;
      r_run_cnt     <= 16'd0;
      r_x_cnt       <= 10'd0;
      r_y_cnt       <= 9'd0;
      r_lit_acc     <= 20'd0;
      r_sig         <= 32'd0;
      r_last_width  <= 10'd0;
      r_frame_lines <= 9'd0;
      r_lit_count   <= 20'd0;
      r_signature   <= 32'd0;
      r_frame_count <= 32'd0;
    end else begin
      r_dclk_q <= dclk;
      if (w_smp && r_state != ST_IDLE) begin
        r_de_q    <= de;
        r_run_cnt <= de ? 16'd0 : w_run_next;
        if (r_state == ST_SYNC || w_frame) begin
          r_x_cnt   <= 10'd0;
          r_y_cnt   <= 9'd0;
          r_lit_acc <= 20'd0;
          r_sig     <= 32'd0;
        end else if (de) begin
          r_x_cnt   <= r_x_cnt + 10'd1;
          r_lit_acc <= r_lit_acc + {19'd0, w_lit};
          r_sig     <= {r_sig[30:0], r_sig[31] ^ w_lit};
        end else if (r_de_q) begin
          r_last_width <= r_x_cnt;
          r_x_cnt      <= 10'd0;
          if (r_y_cnt != 9'h1FF) r_y_cnt <= r_y_cnt + 9'd1;
        end
      end
      if (w_latch) begin
        r_frame_lines <= r_y_cnt;
        r_lit_count   <= r_lit_acc;
        r_signature   <= r_sig;
        r_frame_count <= r_frame_count + 32'd1;
      end
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (w_reg)
      10'd0:   w_rdata = {31'd0, r_ctrl_en};
      10'd1:   w_rdata = {27'd0, r_sticky, w_active};
      10'd2:   w_rdata = r_frame_count;
      10'd3:   w_rdata = {6'd0, r_last_width, 7'd0, r_frame_lines};
      10'd4:   w_rdata = {12'd0, r_lit_count};
      10'd5:   w_rdata = r_signature;
      default: w_rdata = 32'd0;
    endcase
  end

  // A same-cycle hardware set overrides the write-1-to-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready   <= 1'b0;
      r_data_o  <= 32'd0;
      r_ctrl_en <= 1'b0;
      r_sticky  <= 4'd0;
    end else begin
      r_ready  <= w_access;
      r_data_o <= w_access ? w_rdata : 32'd0;
      if (w_access && bus.wstrb[0] && w_reg == 10'd0) r_ctrl_en <= bus.data_i[0];
      r_sticky <= (r_sticky & ~w_w1c) | w_sticky_set;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_capture.sv
`default_nettype none
// ============================================================================
// tb_lcd_capture
// Directed bench for lcd_capture using a reduced 8x4 frame geometry.
// Revision: 1.0
// ============================================================================
module tb_lcd_capture;
  localparam int W = 8, H = 4, VB = 20, HBLANK = 3, VBLANK = 25;
  localparam logic [11:0] A_CTRL = 12'h000, A_STAT = 12'h004, A_FC = 12'h008,
                          A_GEOM = 12'h00C, A_LIT = 12'h010, A_SIG = 12'h014;

  logic       clk = 1'b0, rst_n = 1'b0, dclk = 1'b0, de = 1'b0;
  logic [7:0] red = 8'd0, green = 8'd0, blue = 8'd0;
  logic [31:0] rd;
  int n_checks = 0, n_errors = 0;

  lcd_capture_if bus();

  lcd_capture #(.EXP_WIDTH(W), .EXP_HEIGHT(H), .VBLANK_MIN(VB)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dclk(dclk), .de(de),
    .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic smp_px(input logic d, input logic [23:0] rgb);
    de = d; {red, green, blue} = rgb; dclk = 1'b1;
    @(posedge clk); #1;
    dclk = 1'b0;
    @(posedge clk); #1;
  endtask

  // Line 0 carries the lit mask and an optional grey pixel; short_ln is one pixel narrow.
  task automatic drive_lines(input int lines, input int short_ln, input logic [7:0] lit0, input int gray_px);
    for (int ln = 0; ln < lines; ln++) begin
      for (int p = 0; p < ((ln == short_ln) ? W - 1 : W); p++) begin
        if (ln == 0 && lit0[p])            smp_px(1'b1, 24'hFFFFFF);
        else if (ln == 0 && p == gray_px)  smp_px(1'b1, 24'h808080);
        else                               smp_px(1'b1, 24'h000000);
      end
      for (int b = 0; b < HBLANK; b++) smp_px(1'b0, 24'h0);
    end
  endtask

  task automatic drive_vblank();
    for (int b = 0; b < VBLANK; b++) smp_px(1'b0, 24'h0);
  endtask

  task automatic drive_frame(input int lines, input int short_ln, input logic [7:0] lit0, input int gray_px);
    drive_lines(lines, short_ln, lit0, gray_px);
    drive_vblank();
  endtask

  task automatic bus_xfer(input logic [11:0] a, input logic [3:0] s, input logic [31:0] wd,
                          output logic [31:0] rdata);
    int n;
    bus.select = 1'b1; bus.addr = a; bus.wstrb = s; bus.data_i = wd;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.ready && n < 8);
    if (!bus.ready) check("bus_timeout", 32'd0, 32'd1);
    rdata = bus.data_o;
    bus.select = 1'b0; bus.wstrb = 4'd0;
    @(posedge clk); #1;
  endtask

  task automatic bus_wr(input logic [11:0] a, input logic [3:0] s, input logic [31:0] wd);
    logic [31:0] dummy;
    bus_xfer(a, s, wd, dummy);
  endtask

  task automatic bus_rd(input logic [11:0] a, output logic [31:0] rdata);
    bus_xfer(a, 4'd0, 32'd0, rdata);
  endtask

  task automatic expect_reg(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_rd(a, v);
    check(tag, v, exp);
  endtask

  initial begin
    bus.select = 1'b0; bus.wstrb = 4'd0; bus.addr = 12'd0; bus.data_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_data_o", bus.data_o, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) expect_reg("rst_reg", 12'(i * 4), 32'd0);

    bus_wr(A_CTRL, 4'h1, 32'd1);
    expect_reg("ctrl_en", A_CTRL, 32'd1);
    bus_wr(A_CTRL, 4'h2, 32'd0);
    expect_reg("ctrl_strb", A_CTRL, 32'd1);

    // First frame only synchronises.
    drive_frame(H, -1, 8'h00, -1);
    expect_reg("sync_stat", A_STAT, 32'h01);
    expect_reg("sync_fc", A_FC, 32'd0);

    drive_frame(H, -1, 8'h00, -1);
    expect_reg("dark_fc", A_FC, 32'd1);
    expect_reg("dark_geom", A_GEOM, 32'h0008_0004);
    expect_reg("dark_lit", A_LIT, 32'd0);
    expect_reg("dark_sig", A_SIG, 32'd0);
    expect_reg("dark_stat", A_STAT, 32'h11);

    bus_wr(A_STAT, 4'h1, 32'h10);
    expect_reg("done_w1c", A_STAT, 32'h01);

    drive_frame(H, -1, 8'h01, -1);
    expect_reg("px00_fc", A_FC, 32'd2);
    expect_reg("px00_lit", A_LIT, 32'd1);
    expect_reg("px00_sig", A_SIG, 32'h8000_0000);
    expect_reg("px00_stat", A_STAT, 32'h11);

    drive_frame(H, -1, 8'hFF, -1);
    expect_reg("line0_lit", A_LIT, 32'd8);
    expect_reg("line0_sig", A_SIG, 32'hFF00_0000);

    drive_frame(H, 2, 8'h00, -1);
    expect_reg("width_stat", A_STAT, 32'h13);
    expect_reg("width_geom", A_GEOM, 32'h0008_0004);
    bus_wr(A_STAT, 4'h1, 32'h02);
    expect_reg("width_w1c", A_STAT, 32'h11);
    bus_wr(A_STAT, 4'h2, 32'h10);
    expect_reg("stat_strb", A_STAT, 32'h11);
    bus_wr(A_STAT, 4'h1, 32'h10);

    drive_frame(3, -1, 8'h01, 1);
    expect_reg("hgt_stat", A_STAT, 32'h1D);
    expect_reg("hgt_geom", A_GEOM, 32'h0008_0003);
    expect_reg("hgt_lit", A_LIT, 32'd1);
    expect_reg("hgt_sig", A_SIG, 32'h0080_0000);
    expect_reg("hgt_fc", A_FC, 32'd5);

    // Held-select read timing.
    bus.select = 1'b1; bus.addr = A_FC; bus.wstrb = 4'd0;
    check("lat_c0", {31'd0, bus.ready}, 32'd0);
    @(posedge clk); #1;
    check("lat_c1", {31'd0, bus.ready}, 32'd1);
    check("lat_data", bus.data_o, 32'd5);
    @(posedge clk); #1;
    check("lat_c2", {31'd0, bus.ready}, 32'd0);
    bus.select = 1'b0;
    @(posedge clk); #1;
    check("lat_c3", {31'd0, bus.ready}, 32'd0);

    expect_reg("unmapped", 12'h100, 32'd0);
    bus_wr(A_FC, 4'hF, 32'h0000_FFFF);
    expect_reg("ro_fc", A_FC, 32'd5);
    bus_wr(A_STAT, 4'h1, 32'h1E);
    expect_reg("clr_all", A_STAT, 32'h01);

    // EN dropped mid-frame, then restored mid-frame.
    drive_lines(2, -1, 8'h00, -1);
    bus_wr(A_CTRL, 4'h1, 32'd0);
    expect_reg("dis_stat", A_STAT, 32'h00);
    expect_reg("dis_fc", A_FC, 32'd5);
    expect_reg("dis_lit", A_LIT, 32'd1);
    bus_wr(A_CTRL, 4'h1, 32'd1);
    drive_lines(2, -1, 8'h00, -1);
    drive_vblank();
    expect_reg("reen_fc", A_FC, 32'd5);
    expect_reg("reen_stat", A_STAT, 32'h01);
    drive_frame(H, -1, 8'h00, -1);
    expect_reg("reen_fc2", A_FC, 32'd6);
    expect_reg("reen_stat2", A_STAT, 32'h11);

    // Asynchronous reset mid-frame while read data is on the bus.
    drive_lines(2, -1, 8'h00, -1);
    bus.select = 1'b1; bus.addr = A_FC; bus.wstrb = 4'd0;
    @(posedge clk); #1;
    check("prerst_data", bus.data_o, 32'd6);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", {31'd0, bus.ready}, 32'd0);
    check("arst_data", bus.data_o, 32'd0);
    bus.select = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) expect_reg("arst_reg", 12'(i * 4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
